// File: rtl/orion_types.sv
// Shared types for the issue controller.
//   SB_CNT_W      default width of a per-register pending-write counter
//   REG_IDX_W     width of an architectural register index
//   issue_state_t flush sequencer states
package orion_types;

  localparam int unsigned SB_CNT_W  = 2;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic {
    ISS_IDLE,
    ISS_FLUSH
  } issue_state_t;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one saturating-free counter per register (x0 never tracked).
//   clk, rst        clock, async active-high reset
//   inc, inc_idx    an issuing instruction will write inc_idx
//   dec, dec_idx    writeback commits dec_idx
//   rs1_idx/rs2_idx source lookups -> rs1_busy/rs2_busy (pending write outstanding)
//   rd_idx          destination lookup -> rd_full (counter at maximum)
//   busy            any counter nonzero
//   err             sticky: writeback seen for a register with nothing pending
module issue_ctrl_scoreboard
  import orion_types::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic [REG_IDX_W-1:0] inc_idx,
  input  logic                 dec,
  input  logic [REG_IDX_W-1:0] dec_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_full,
  output logic                 busy,
  output logic                 err
);

  logic [CNT_W-1:0] cnt   [NREGS];
  logic [CNT_W-1:0] cnt_n [NREGS];
  logic             err_set;
  logic             hit_inc;
  logic             hit_dec;

  always_comb begin
    cnt_n   = cnt;
    err_set = 1'b0;
    hit_inc = 1'b0;
    hit_dec = 1'b0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      hit_inc = inc && (inc_idx == REG_IDX_W'(r));
      hit_dec = dec && (dec_idx == REG_IDX_W'(r));
      if (hit_dec && cnt[r] == '0) err_set = 1'b1;
      // Simultaneous inc and dec on one register cancel out.
      if (hit_inc && !hit_dec) begin
        cnt_n[r] = cnt[r] + 1'b1;
      end else if (hit_dec && !hit_inc && cnt[r] != '0) begin
        cnt_n[r] = cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '{default: '0};
      err <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (cnt[r] != '0) busy = 1'b1;
    end
  end

  assign rs1_busy = (rs1_idx != '0) && (cnt[rs1_idx] != '0);
  assign rs2_busy = (rs2_idx != '0) && (cnt[rs2_idx] != '0);
  assign rd_full  = (rd_idx  != '0) && (cnt[rd_idx]  == '1);

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: gates ID->EX issue on scoreboard hazards, sequences pipeline
// flushes after EX redirects, and counts hazard-stall cycles.
//   clk_i, rst_i             clock, async active-high reset
//   id_*                     instruction held in decode (sources, destination, valid)
//   ex_ready_i               EX can accept this cycle
//   redirect_i               EX resolved a taken control transfer
//   wb_rd_s_i, wb_rd_we_i    writeback commit
//   issue_o, stall_o         issue / hold-fetch-and-decode
//   flush_req_o              invalidate instruction in ID
//   busy_o                   any write pending
//   stall_cnt_o              saturating hazard-stall cycle count
//   sb_err_o                 sticky spurious-writeback flag
module issue_ctrl
  import orion_types::*;
#(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned CNT_W        = SB_CNT_W,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_s_i,
  input  logic [4:0]  id_rs2_s_i,
  input  logic        id_rs1_use_i,
  input  logic        id_rs2_use_i,
  input  logic [4:0]  id_rd_s_i,
  input  logic        id_rd_we_i,
  input  logic        ex_ready_i,
  input  logic        redirect_i,
  input  logic [4:0]  wb_rd_s_i,
  input  logic        wb_rd_we_i,
  output logic        issue_o,
  output logic        stall_o,
  output logic        flush_req_o,
  output logic        busy_o,
  output logic [31:0] stall_cnt_o,
  output logic        sb_err_o
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD =
    (FLUSH_CYCLES > 0) ? FCNT_W'(FLUSH_CYCLES - 1) : '0;

  issue_state_t      state, state_n;
  logic [FCNT_W-1:0] fcnt, fcnt_n;

  logic rs1_busy, rs2_busy, rd_full;
  logic hazard;

  issue_ctrl_scoreboard #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk      (clk_i),
    .rst      (rst_i),
    .inc      (issue_o && id_rd_we_i),
    .inc_idx  (id_rd_s_i),
    .dec      (wb_rd_we_i),
    .dec_idx  (wb_rd_s_i),
    .rs1_idx  (id_rs1_s_i),
    .rs2_idx  (id_rs2_s_i),
    .rd_idx   (id_rd_s_i),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_full  (rd_full),
    .busy     (busy_o),
    .err      (sb_err_o)
  );

  // No writeback bypass: a source retiring this cycle still blocks issue.
  assign hazard = (id_rs1_use_i && rs1_busy)
               || (id_rs2_use_i && rs2_busy)
               || (id_rd_we_i   && rd_full);

  assign flush_req_o = redirect_i || (state == ISS_FLUSH);
  assign issue_o     = id_valid_i && !hazard && ex_ready_i && !flush_req_o;
  assign stall_o     = id_valid_i && !issue_o && !flush_req_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ISS_IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    unique case (state)
      ISS_IDLE: begin
        if (redirect_i && FLUSH_CYCLES > 0) begin
          state_n = ISS_FLUSH;
          fcnt_n  = FCNT_LOAD;
        end
      end
      ISS_FLUSH: begin
        if (redirect_i) begin
          fcnt_n = FCNT_LOAD;
        end else if (fcnt == '0) begin
          state_n = ISS_IDLE;
        end else begin
          fcnt_n = fcnt - 1'b1;
        end
      end
      default: state_n = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (id_valid_i && hazard && !flush_req_o && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_s_i, id_rs2_s_i, id_rd_s_i, wb_rd_s_i;
  logic        id_rs1_use_i, id_rs2_use_i, id_rd_we_i;
  logic        ex_ready_i, redirect_i, wb_rd_we_i;
  logic        issue_o, stall_o, flush_req_o, busy_o, sb_err_o;
  logic [31:0] stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  issue_ctrl #(
    .NREGS        (32),
    .CNT_W        (2),
    .FLUSH_CYCLES (1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs1_s_i   (id_rs1_s_i),
    .id_rs2_s_i   (id_rs2_s_i),
    .id_rs1_use_i (id_rs1_use_i),
    .id_rs2_use_i (id_rs2_use_i),
    .id_rd_s_i    (id_rd_s_i),
    .id_rd_we_i   (id_rd_we_i),
    .ex_ready_i   (ex_ready_i),
    .redirect_i   (redirect_i),
    .wb_rd_s_i    (wb_rd_s_i),
    .wb_rd_we_i   (wb_rd_we_i),
    .issue_o      (issue_o),
    .stall_o      (stall_o),
    .flush_req_o  (flush_req_o),
    .busy_o       (busy_o),
    .stall_cnt_o  (stall_cnt_o),
    .sb_err_o     (sb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid_i   = 1'b0;
    id_rs1_s_i   = '0;
    id_rs2_s_i   = '0;
    id_rs1_use_i = 1'b0;
    id_rs2_use_i = 1'b0;
    id_rd_s_i    = '0;
    id_rd_we_i   = 1'b0;
    ex_ready_i   = 1'b1;
    redirect_i   = 1'b0;
    wb_rd_s_i    = '0;
    wb_rd_we_i   = 1'b0;
  endtask

  // Inputs change on the falling edge; checks happen 1ns later, well before the rising edge.
  task automatic nxt();
    @(negedge clk_i);
    idle();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    #1;
    chk("rst_issue", issue_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_flush", flush_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stallcnt", stall_cnt_o, 0);
    chk("rst_sberr", sb_err_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Test 1: ADD x5, then a reader of x5 waits for WB x5
    nxt(); id_valid_i = 1; id_rd_s_i = 5; id_rd_we_i = 1; #1;
    chk("t1_issue_w5", issue_o, 1);
    chk("t1_nostall_w5", stall_o, 0);
    nxt(); id_valid_i = 1; id_rs1_s_i = 5; id_rs1_use_i = 1; #1;
    chk("t1_raw_issue", issue_o, 0);
    chk("t1_raw_stall", stall_o, 1);
    chk("t1_busy", busy_o, 1);
    nxt(); id_valid_i = 1; id_rs1_s_i = 5; id_rs1_use_i = 1; wb_rd_s_i = 5; wb_rd_we_i = 1; #1;
    chk("t1_nobypass_issue", issue_o, 0);
    chk("t1_nobypass_stall", stall_o, 1);
    nxt(); id_valid_i = 1; id_rs1_s_i = 5; id_rs1_use_i = 1; #1;
    chk("t1_after_wb_issue", issue_o, 1);
    chk("t1_after_wb_busy", busy_o, 0);
    chk("t1_stallcnt", stall_cnt_o, 2);

    // Test 2: x0 sources never stall, x0 destination never tracked
    nxt(); id_valid_i = 1; id_rs1_s_i = 0; id_rs1_use_i = 1; id_rs2_use_i = 1;
    id_rd_s_i = 0; id_rd_we_i = 1; #1;
    chk("t2_x0_issue", issue_o, 1);
    chk("t2_x0_stall", stall_o, 0);
    nxt(); #1;
    chk("t2_x0_busy", busy_o, 0);
    chk("t2_novalid_stall", stall_o, 0);

    // EX not ready: stall without counting a hazard
    nxt(); id_valid_i = 1; ex_ready_i = 0; #1;
    chk("exrdy_issue", issue_o, 0);
    chk("exrdy_stall", stall_o, 1);

    // Test 3: counter saturation on x7 blocks the 4th writer
    for (int unsigned k = 0; k < 3; k++) begin
      nxt(); id_valid_i = 1; id_rd_s_i = 7; id_rd_we_i = 1; #1;
      chk("t3_issue_w7", issue_o, 1);
    end
    nxt(); id_valid_i = 1; id_rd_s_i = 7; id_rd_we_i = 1; #1;
    chk("t3_full_issue", issue_o, 0);
    chk("t3_full_stall", stall_o, 1);
    chk("t3_stallcnt_exrdy", stall_cnt_o, 2);
    nxt(); id_valid_i = 1; id_rd_s_i = 7; id_rd_we_i = 1; wb_rd_s_i = 7; wb_rd_we_i = 1; #1;
    chk("t3_full_wb_issue", issue_o, 0);
    nxt(); id_valid_i = 1; id_rd_s_i = 7; id_rd_we_i = 1; #1;
    chk("t3_after_wb_issue", issue_o, 1);
    for (int unsigned k = 0; k < 3; k++) begin
      nxt(); wb_rd_s_i = 7; wb_rd_we_i = 1; #1;
      chk("t3_drain_busy", busy_o, 1);
    end
    nxt(); #1;
    chk("t3_drained_busy", busy_o, 0);
    chk("t3_stallcnt", stall_cnt_o, 4);

    // Test 4: same-cycle issue and WB of x3 leave the count at 1
    nxt(); id_valid_i = 1; id_rd_s_i = 3; id_rd_we_i = 1; #1;
    chk("t4_issue_w3", issue_o, 1);
    nxt(); id_valid_i = 1; id_rd_s_i = 3; id_rd_we_i = 1; wb_rd_s_i = 3; wb_rd_we_i = 1; #1;
    chk("t4_issue_wb_same", issue_o, 1);
    nxt(); id_valid_i = 1; id_rs2_s_i = 3; id_rs2_use_i = 1; wb_rd_s_i = 3; wb_rd_we_i = 1; #1;
    chk("t4_cnt1_stall", stall_o, 1);
    nxt(); id_valid_i = 1; id_rs2_s_i = 3; id_rs2_use_i = 1; #1;
    chk("t4_cnt0_issue", issue_o, 1);
    chk("t4_busy", busy_o, 0);
    chk("t4_sberr", sb_err_o, 0);

    // Test 5: redirect flushes two cycles; a second redirect extends by one
    nxt(); id_valid_i = 1; id_rd_s_i = 10; id_rd_we_i = 1; redirect_i = 1; #1;
    chk("t5_redir_flush", flush_req_o, 1);
    chk("t5_redir_issue", issue_o, 0);
    chk("t5_redir_stall", stall_o, 0);
    nxt(); id_valid_i = 1; id_rd_s_i = 10; id_rd_we_i = 1; #1;
    chk("t5_flush2", flush_req_o, 1);
    chk("t5_flush2_issue", issue_o, 0);
    chk("t5_flush2_busy", busy_o, 0);
    nxt(); #1;
    chk("t5_flush_done", flush_req_o, 0);
    chk("t5_no_wrongpath_busy", busy_o, 0);
    nxt(); redirect_i = 1; #1;
    chk("t5b_flush1", flush_req_o, 1);
    nxt(); id_valid_i = 1; id_rs1_s_i = 10; id_rs1_use_i = 1; redirect_i = 1; #1;
    chk("t5b_flush2", flush_req_o, 1);
    nxt(); id_valid_i = 1; id_rd_s_i = 10; id_rd_we_i = 1; #1;
    chk("t5b_flush3_ext", flush_req_o, 1);
    chk("t5b_flush3_issue", issue_o, 0);
    nxt(); #1;
    chk("t5b_flush_done", flush_req_o, 0);
    chk("t5b_busy", busy_o, 0);

    // Test 6: WB to idle x9 sets the sticky error flag
    nxt(); wb_rd_s_i = 9; wb_rd_we_i = 1; #1;
    chk("t6_sberr_before", sb_err_o, 0);
    nxt(); #1;
    chk("t6_sberr_set", sb_err_o, 1);
    chk("t6_busy", busy_o, 0);
    nxt(); #1;
    chk("t6_sberr_sticky", sb_err_o, 1);
    chk("t6_stallcnt_total", stall_cnt_o, 5);

    // Async reset mid-operation, then a stale writeback
    nxt(); id_valid_i = 1; id_rd_s_i = 12; id_rd_we_i = 1; #1;
    chk("rst2_issue_w12", issue_o, 1);
    nxt(); #2; rst_i = 1'b1; #1;
    chk("rst2_busy", busy_o, 0);
    chk("rst2_stallcnt", stall_cnt_o, 0);
    chk("rst2_sberr", sb_err_o, 0);
    nxt(); rst_i = 1'b0; wb_rd_s_i = 12; wb_rd_we_i = 1; #1;
    chk("rst2_sberr_pre", sb_err_o, 0);
    nxt(); #1;
    chk("rst2_stale_wb_sberr", sb_err_o, 1);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
